// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the instruction-ROM arbiter: bus widths, port ids
// and arbitration mode encodings.
package rom_arbiter_pkg;

    // ROM port widths follow the register bus width.
    localparam int REG_BUS_W  = 32;
    localparam int ROM_ADDR_W = REG_BUS_W;
    localparam int ROM_DATA_W = REG_BUS_W;

    typedef enum logic {
        PORT_M0 = 1'b0,
        PORT_M1 = 1'b1
    } port_e;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    function automatic logic [1:0] port_onehot(input port_e port);
        return (port == PORT_M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter: fetch port (m0) and debug/loader
// port (m1). Requesters use the master modport, the arbiter the slave modport.
interface rom_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_gnt;
    logic              m0_flush;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    modport master (
        output m0_req, m0_addr, m0_flush, m1_req, m1_addr,
        input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata
    );

    modport slave (
        input  m0_req, m0_addr, m0_flush, m1_req, m1_addr,
        output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata
    );
endinterface

// File: rtl/rom_arbiter_arb2_rr.sv
// Two-way request arbiter with a last-served pointer; round-robin or
// fixed priority (port 0 wins) selected by PRIO_MODE.
module arb2_rr
    import rom_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    port_e last_q;
    port_e last_d;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_o = 2'b00;
        if (!rst) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11: begin
                    if (PRIO_MODE == PRIO_FIXED || last_q == PORT_M1) begin
                        gnt_o = port_onehot(PORT_M0);
                    end else begin
                        gnt_o = port_onehot(PORT_M1);
                    end
                end
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // The pointer only moves when somebody is actually granted.
    always_comb begin
        last_d = last_q;
        if (gnt_o[0]) begin
            last_d = PORT_M0;
        end else if (gnt_o[1]) begin
            last_d = PORT_M1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT_M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one instruction ROM port between the fetch port and the debug port:
// grant, registered issue stage, registered response stage, fetch flush.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ROM_ADDR_W,
    parameter int DATA_W    = ROM_DATA_W,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic              clk,
    input  logic              rst,
    rom_arbiter_if.slave      bus,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    logic [1:0] gnt;

    arb2_rr #(
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({bus.m1_req, bus.m0_req}),
        .gnt_o (gnt)
    );

    assign bus.m0_gnt = gnt[0];
    assign bus.m1_gnt = gnt[1];

    // Issue stage: the request being presented to the ROM this cycle.
    logic              iss_vld_q, iss_vld_d;
    port_e             iss_tag_q, iss_tag_d;
    logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;

    // Response stage: per-port valid pulse and held read data.
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    always_comb begin
        iss_vld_d  = |gnt;
        iss_tag_d  = gnt[1] ? PORT_M1 : PORT_M0;
        iss_addr_d = iss_addr_q;
        if (gnt[1]) begin
            iss_addr_d = bus.m1_addr;
        end else if (gnt[0]) begin
            iss_addr_d = bus.m0_addr;
        end
    end

    // A flush kills only a fetch already sitting in the issue stage; a fetch
    // granted in the flush cycle is the new target and survives.
    always_comb begin
        m0_rvalid_d = iss_vld_q && (iss_tag_q == PORT_M0) && !bus.m0_flush;
        m1_rvalid_d = iss_vld_q && (iss_tag_q == PORT_M1);
        m0_rdata_d  = m0_rvalid_d ? rom_data_i : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? rom_data_i : m1_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld_q   <= 1'b0;
            iss_tag_q   <= PORT_M0;
            iss_addr_q  <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            iss_vld_q   <= iss_vld_d;
            iss_tag_q   <= iss_tag_d;
            iss_addr_q  <= iss_addr_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    // Outputs read as zero for the whole reset cycle, so a response already in
    // the response stage when reset arrives is never seen by its owner.
    assign rom_ce_o      = iss_vld_q & ~rst;
    assign rom_addr_o    = rst ? '0 : iss_addr_q;
    assign bus.m0_rvalid = m0_rvalid_q & ~rst;
    assign bus.m1_rvalid = m1_rvalid_q & ~rst;
    assign bus.m0_rdata  = rst ? '0 : m0_rdata_q;
    assign bus.m1_rdata  = rst ? '0 : m1_rdata_q;

endmodule
